// File: rtl/sram_port_arbiter_if.sv
// Client handshake and sram-side signals of the two-port sram arbiter.
// slave = arbiter side, master = clients plus the sram model.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 2
) ();
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, ready,
           mem_addr, mem_we, mem_din
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, ready,
           mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-client round-robin sequencer for the latch-based sram: clears the array
// after reset, then runs one setup/strobe/hold write or setup/sample read at a time.
//
// state        | meaning
// INIT_SETUP   | init sweep: address/data settle for word init_cnt
// INIT_STROBE  | init sweep: write_enable pulse
// INIT_HOLD    | init sweep: address/data held after the pulse
// IDLE         | ready; arbitrate and grant one request
// W_SETUP      | client write: address/data settle
// W_STROBE     | client write: write_enable pulse
// W_HOLD       | client write: hold, done issued on exit
// R_SETUP      | client read: address settles
// R_SAMPLE     | client read: capture d_out, done issued on exit
module sram_port_arbiter #(
  parameter int               ADDR_W     = 2,
  parameter int               DATA_W     = 2,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic               clk,
  input  logic               reset,
  sram_port_arbiter_if.slave bus
);

  localparam logic [3:0] S_INIT_SETUP  = 4'd0;
  localparam logic [3:0] S_INIT_STROBE = 4'd1;
  localparam logic [3:0] S_INIT_HOLD   = 4'd2;
  localparam logic [3:0] S_IDLE        = 4'd3;
  localparam logic [3:0] S_W_SETUP     = 4'd4;
  localparam logic [3:0] S_W_STROBE    = 4'd5;
  localparam logic [3:0] S_W_HOLD      = 4'd6;
  localparam logic [3:0] S_R_SETUP     = 4'd7;
  localparam logic [3:0] S_R_SAMPLE    = 4'd8;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [3:0]        state;
  logic [3:0]        state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic              rr;
  logic              cur_id;

  logic              pick_valid;
  logic              pick_id;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;

  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;
  logic              mem_we_q;
  logic              done0_q;
  logic              done1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              ready_q;

  // Grant is combinational so it lands in the IDLE cycle itself; gated by
  // reset so nothing is accepted while reset is being applied.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = 1'b0;
    if (state == S_IDLE && !reset) begin
      if (bus.req0 && bus.req1) begin
        pick_valid = 1'b1;
        pick_id    = rr;
      end else if (bus.req0) begin
        pick_valid = 1'b1;
        pick_id    = 1'b0;
      end else if (bus.req1) begin
        pick_valid = 1'b1;
        pick_id    = 1'b1;
      end
    end
  end

  always_comb begin
    pick_we    = pick_id ? bus.we1    : bus.we0;
    pick_addr  = pick_id ? bus.addr1  : bus.addr0;
    pick_wdata = pick_id ? bus.wdata1 : bus.wdata0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT_SETUP:  state_nxt = S_INIT_STROBE;
      S_INIT_STROBE: state_nxt = S_INIT_HOLD;
      S_INIT_HOLD:   state_nxt = (init_cnt == LAST_ADDR) ? S_IDLE : S_INIT_SETUP;
      S_IDLE: begin
        if (pick_valid) state_nxt = pick_we ? S_W_SETUP : S_R_SETUP;
      end
      S_W_SETUP:     state_nxt = S_W_STROBE;
      S_W_STROBE:    state_nxt = S_W_HOLD;
      S_W_HOLD:      state_nxt = S_IDLE;
      S_R_SETUP:     state_nxt = S_R_SAMPLE;
      S_R_SAMPLE:    state_nxt = S_IDLE;
      default:       state_nxt = S_INIT_SETUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_INIT_SETUP;
      init_cnt   <= '0;
      rr         <= 1'b0;
      cur_id     <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      mem_we_q <= (state_nxt == S_INIT_STROBE) || (state_nxt == S_W_STROBE);
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      case (state)
        S_INIT_SETUP, S_INIT_STROBE: begin
          mem_din_q <= INIT_VALUE;
        end
        S_INIT_HOLD: begin
          mem_din_q <= INIT_VALUE;
          // Counter parks on the last word; ready marks the end of the sweep.
          if (init_cnt == LAST_ADDR) begin
            ready_q <= 1'b1;
          end else begin
            init_cnt   <= init_cnt + 1'b1;
            mem_addr_q <= init_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (pick_valid) begin
            cur_id     <= pick_id;
            rr         <= ~pick_id;
            mem_addr_q <= pick_addr;
            mem_din_q  <= pick_wdata;
          end
        end
        S_W_HOLD: begin
          done0_q <= ~cur_id;
          done1_q <= cur_id;
        end
        S_R_SAMPLE: begin
          done0_q <= ~cur_id;
          done1_q <= cur_id;
          if (cur_id) rdata1_q <= bus.mem_dout;
          else        rdata0_q <= bus.mem_dout;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt0     = pick_valid & ~pick_id;
  assign bus.gnt1     = pick_valid & pick_id;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.ready    = ready_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_din  = mem_din_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 4x2 sram model.
module tb_sram_port_arbiter;

  logic clk;
  logic reset;
  logic fill;
  int   total;
  int   bad;
  logic [1:0] r0_exp;
  logic [1:0] r1_exp;
  logic [1:0] sram_m [4];

  sram_port_arbiter_if #(.ADDR_W(2), .DATA_W(2)) bus ();

  sram_port_arbiter #(.ADDR_W(2), .DATA_W(2), .INIT_VALUE(2'b00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array starts at 2'b11 everywhere so only the init sweep can clear it.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 4; i++) sram_m[i] <= 2'b11;
    end else if (bus.mem_we) begin
      sram_m[bus.mem_addr] <= bus.mem_din;
    end
  end
  assign bus.mem_dout = sram_m[bus.mem_addr];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit c, input logic r, input logic w,
                     input logic [1:0] a, input logic [1:0] d);
    if (c) begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  task automatic wr(input bit c, input logic [1:0] a, input logic [1:0] d);
    @(negedge clk);
    drv(c, 1'b1, 1'b1, a, d);
    #1;
    chk("wr_gnt", 8'(c ? bus.gnt1 : bus.gnt0), 8'd1);
    chk("wr_gnt_other", 8'(c ? bus.gnt0 : bus.gnt1), 8'd0);
    @(negedge clk);
    drv(c, 1'b0, 1'b0, 2'b00, 2'b00);
    #1;
    chk("wr_setup_we", 8'(bus.mem_we), 8'd0);
    chk("wr_setup_addr", 8'(bus.mem_addr), 8'(a));
    @(negedge clk); #1;
    chk("wr_strobe_we", 8'(bus.mem_we), 8'd1);
    chk("wr_strobe_addr", 8'(bus.mem_addr), 8'(a));
    chk("wr_strobe_din", 8'(bus.mem_din), 8'(d));
    @(negedge clk); #1;
    chk("wr_hold_we", 8'(bus.mem_we), 8'd0);
    chk("wr_hold_din", 8'(bus.mem_din), 8'(d));
    chk("wr_hold_done", 8'(c ? bus.done1 : bus.done0), 8'd0);
    @(negedge clk); #1;
    chk("wr_done", 8'(c ? bus.done1 : bus.done0), 8'd1);
    chk("wr_done_other", 8'(c ? bus.done0 : bus.done1), 8'd0);
  endtask

  task automatic rd(input bit c, input logic [1:0] a, input logic [1:0] d);
    @(negedge clk);
    drv(c, 1'b1, 1'b0, a, 2'b00);
    #1;
    chk("rd_gnt", 8'(c ? bus.gnt1 : bus.gnt0), 8'd1);
    chk("rd_gnt_other", 8'(c ? bus.gnt0 : bus.gnt1), 8'd0);
    @(negedge clk);
    drv(c, 1'b0, 1'b0, 2'b00, 2'b00);
    #1;
    chk("rd_setup_addr", 8'(bus.mem_addr), 8'(a));
    chk("rd_setup_we", 8'(bus.mem_we), 8'd0);
    @(negedge clk); #1;
    chk("rd_sample_done", 8'(c ? bus.done1 : bus.done0), 8'd0);
    @(negedge clk); #1;
    if (c) r1_exp = d; else r0_exp = d;
    chk("rd_done", 8'(c ? bus.done1 : bus.done0), 8'd1);
    chk("rd_done_other", 8'(c ? bus.done0 : bus.done1), 8'd0);
    chk("rd_rdata0", 8'(bus.rdata0), 8'(r0_exp));
    chk("rd_rdata1", 8'(bus.rdata1), 8'(r1_exp));
  endtask

  initial begin
    int  n_ready;
    bit  saw_done;
    total  = 0;
    bad    = 0;
    r0_exp = 2'b00;
    r1_exp = 2'b00;
    reset  = 1'b1;
    fill   = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    drv(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);

    // cycle 0: in reset
    @(negedge clk);
    fill = 1'b0;
    // both clients request reads (addr 1 / addr 3) throughout init
    drv(1'b0, 1'b1, 1'b0, 2'd1, 2'b00);
    drv(1'b1, 1'b1, 1'b0, 2'd3, 2'b00);
    #1;
    chk("rst_mem_we", 8'(bus.mem_we), 8'd0);
    chk("rst_mem_addr", 8'(bus.mem_addr), 8'd0);
    chk("rst_mem_din", 8'(bus.mem_din), 8'd0);
    chk("rst_ready", 8'(bus.ready), 8'd0);
    chk("rst_gnt", 8'({bus.gnt0, bus.gnt1}), 8'd0);
    chk("rst_done", 8'({bus.done0, bus.done1}), 8'd0);
    chk("rst_rdata", 8'({bus.rdata0, bus.rdata1}), 8'd0);

    // cycle 1: still in reset, release after sampling
    @(negedge clk);
    reset = 1'b0;

    // init sweep: strobes at cycles 2,5,8,11 on addresses 0..3
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk); #1;
      chk("init_we", 8'(bus.mem_we), 8'(((c - 2) % 3) == 0));
      if (((c - 2) % 3) == 0) begin
        chk("init_addr", 8'(bus.mem_addr), 8'((c - 2) / 3));
        chk("init_din", 8'(bus.mem_din), 8'd0);
      end
      chk("init_ready", 8'(bus.ready), 8'd0);
      chk("init_no_gnt", 8'({bus.gnt0, bus.gnt1}), 8'd0);
    end
    @(negedge clk); #1;  // cycle 13: first IDLE
    chk("first_ready", 8'(bus.ready), 8'd1);
    chk("first_gnt0", 8'(bus.gnt0), 8'd1);
    chk("first_gnt1", 8'(bus.gnt1), 8'd0);

    // contention: grants alternate 0,1,0,1 every 3 cycles
    for (int c = 14; c <= 25; c++) begin
      @(negedge clk);
      if (c == 25) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
      #1;
      chk("rr_gnt0", 8'(bus.gnt0), 8'(c == 19));
      chk("rr_gnt1", 8'(bus.gnt1), 8'(c == 16 || c == 22));
      chk("rr_done0", 8'(bus.done0), 8'(c == 16 || c == 22));
      chk("rr_done1", 8'(bus.done1), 8'(c == 19 || c == 25));
    end

    for (int a = 0; a < 4; a++) rd(1'b0, 2'(a), 2'b00);

    // client1 streams writes; client0 joins mid-stream and takes the next IDLE
    @(negedge clk);
    drv(1'b1, 1'b1, 1'b1, 2'd0, 2'd1);
    #1;
    chk("bb_gnt1_k0", 8'(bus.gnt1), 8'd1);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) drv(1'b1, 1'b1, 1'b1, 2'd1, 2'd2);
      if (k == 5) drv(1'b1, 1'b1, 1'b1, 2'd2, 2'd3);
      if (k == 9) begin
        drv(1'b1, 1'b1, 1'b0, 2'd2, 2'd0);
        drv(1'b0, 1'b1, 1'b0, 2'd1, 2'd0);
      end
      if (k == 13) drv(1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
      if (k == 16) drv(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
      #1;
      chk("bb_gnt1", 8'(bus.gnt1), 8'(k == 4 || k == 8 || k == 15));
      chk("bb_gnt0", 8'(bus.gnt0), 8'(k == 12));
      chk("bb_done1", 8'(bus.done1), 8'(k == 4 || k == 8 || k == 12 || k == 18));
      chk("bb_done0", 8'(bus.done0), 8'(k == 15));
      if (k == 15) chk("bb_rdata0", 8'(bus.rdata0), 8'd2);
      if (k == 18) chk("bb_rdata1", 8'(bus.rdata1), 8'd3);
    end
    r0_exp = 2'd2;
    r1_exp = 2'd3;
    rd(1'b1, 2'd0, 2'd1);

    // write then cross-client read of the same word
    wr(1'b0, 2'd2, 2'b10);
    rd(1'b1, 2'd2, 2'b10);

    // reset in the middle of a write strobe
    @(negedge clk);
    drv(1'b1, 1'b1, 1'b1, 2'd3, 2'b11);
    #1;
    chk("ab_gnt1", 8'(bus.gnt1), 8'd1);
    @(negedge clk);
    drv(1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    @(negedge clk); #1;
    chk("ab_strobe_we", 8'(bus.mem_we), 8'd1);
    chk("ab_strobe_addr", 8'(bus.mem_addr), 8'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ab_we_off", 8'(bus.mem_we), 8'd0);
    chk("ab_no_done", 8'({bus.done0, bus.done1}), 8'd0);
    chk("ab_ready_low", 8'(bus.ready), 8'd0);
    chk("ab_rdata_clr", 8'({bus.rdata0, bus.rdata1}), 8'd0);
    r0_exp = 2'b00;
    r1_exp = 2'b00;
    n_ready  = 0;
    saw_done = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk); #1;
      if (bus.done0 || bus.done1) saw_done = 1'b1;
      if (bus.ready) begin
        n_ready = n;
        break;
      end
    end
    chk("ab_reinit_cycles", 8'(n_ready), 8'd12);
    chk("ab_no_late_done", 8'(saw_done), 8'd0);
    rd(1'b1, 2'd3, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
